// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
// Instruction-load and fetch front end feeding the decode stage through an
// IF/ID register. While LoadInstructions is high one 32-bit word per clock is
// streamed into the on-chip instruction memory. Once loading ends, fetch runs
// sequentially from byte address 0, honouring stall and branch redirects.
// Memory contents and load_count are kept across Reset, so a program loaded
// before a reset pulse runs again after it.
//
// Ports:
//   clk              rising-edge clock
//   Reset            asynchronous, active-low reset
//   LoadInstructions load mode, one word written per edge while high
//   Instruction      word to load
//   stall            hold PC and IF/ID outputs
//   branch_taken     redirect fetch to branch_target
//   branch_target    redirect byte address, bits [1:0] forced to zero
//   if_instr         fetched instruction (NOP when if_valid=0)
//   if_pc            byte address of if_instr
//   if_pc_plus4      if_pc + 4, mod 2^32
//   if_valid         if_instr is a real fetched instruction
//   load_count       number of words loaded
//   overflow         a load word was dropped because memory was full
//   fetch_done       PC has run past the last loaded word
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int          DEPTH = 64,
    parameter int          AW    = 6,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          LoadInstructions,
    input  logic [31:0]   Instruction,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    output logic [31:0]   if_instr,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_pc_plus4,
    output logic          if_valid,
    output logic [AW:0]   load_count,
    output logic          overflow,
    output logic          fetch_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_r;
    logic [31:0]   pc_r;
    logic [31:0]   mem_r [DEPTH];

    logic [AW-1:0] fetch_idx_s;
    logic          in_range_s;
    logic          mem_full_s;
    logic          load_start_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [31:0]   target_s;

    // Fetch range check, load write decode and branch target alignment
    always_comb begin
        fetch_idx_s  = pc_r[AW+1:2];
        // Whole 32-bit PC takes part so large addresses never alias into memory
        in_range_s   = ((pc_r >> 2) < {{(31-AW){1'b0}}, load_count});
        mem_full_s   = (load_count >= DEPTH_C);
        target_s     = branch_target & 32'hFFFF_FFFC;
        // A load burst entered from any other state restarts at word 0
        load_start_s = Reset && LoadInstructions && (state_r != ST_LOAD);
        wr_en_s      = 1'b0;
        wr_idx_s     = {AW{1'b0}};
        if (load_start_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = {AW{1'b0}};
        end else if (Reset && LoadInstructions && !mem_full_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = load_count[AW-1:0];
        end else begin
            wr_en_s  = 1'b0;
            wr_idx_s = {AW{1'b0}};
        end
    end

    // Instruction memory and word counter; deliberately untouched by Reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= Instruction;
        end
        if (load_start_s) begin
            load_count <= {{AW{1'b0}}, 1'b1};
        end else if (wr_en_s) begin
            load_count <= load_count + {{AW{1'b0}}, 1'b1};
        end else begin
            load_count <= load_count;
        end
    end

    // Control FSM, PC and registered IF/ID outputs
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= 32'h0000_0000;
            if_instr    <= NOP;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= 32'h0000_0000;
            if_valid    <= 1'b0;
            overflow    <= 1'b0;
            fetch_done  <= 1'b0;
        end else if (LoadInstructions) begin
            // Loading always wins and aborts any fetch in progress
            state_r    <= ST_LOAD;
            pc_r       <= 32'h0000_0000;
            if_instr   <= NOP;
            if_valid   <= 1'b0;
            fetch_done <= 1'b0;
            if (state_r != ST_LOAD) begin
                overflow <= 1'b0;
            end else if (mem_full_s) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (load_count != {(AW+1){1'b0}}) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        // One bubble; if_pc/if_pc_plus4 keep the last fetch
                        pc_r     <= target_s;
                        if_instr <= NOP;
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else if (in_range_s) begin
                        if_instr    <= mem_r[fetch_idx_s];
                        if_pc       <= pc_r;
                        if_pc_plus4 <= pc_r + 32'd4;
                        if_valid    <= 1'b1;
                        pc_r        <= pc_r + 32'd4;
                    end else begin
                        if_instr   <= NOP;
                        if_valid   <= 1'b0;
                        fetch_done <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Stall has no effect here; only a redirect restarts fetch
                    if (branch_taken) begin
                        pc_r       <= target_s;
                        fetch_done <= 1'b0;
                        state_r    <= ST_RUN;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
// Self-checking bench for instr_fetch_stage (DEPTH=4). Directed scenarios
// follow the block's intended use; a randomized phase then mixes loads,
// stalls, branches and reset pulses. Every output is compared each cycle
// against a behavioural model built from the block's rules.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [31:0] NOPW  = 32'h0000_0000;
    localparam logic [31:0] WA    = 32'h2001_0010;
    localparam logic [31:0] WB    = 32'h2002_0018;
    localparam logic [31:0] WC    = 32'h2003_01B4;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic          clk = 1'b0;
    logic          Reset;
    logic          LoadInstructions;
    logic [31:0]   Instruction;
    logic          stall;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc_plus4;
    logic          if_valid;
    logic [AW:0]   load_count;
    logic          overflow;
    logic          fetch_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_count;
    bit          m_count_known;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_valid;
    logic        m_ovf;
    logic        m_done;

    always #5 clk = ~clk;

    instr_fetch_stage #(.DEPTH(DEPTH), .AW(AW), .NOP(NOPW)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .if_valid         (if_valid),
        .load_count       (load_count),
        .overflow         (overflow),
        .fetch_done       (fetch_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pc    = 32'h0;
        m_instr = NOPW;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
    endtask

    // One clock edge of the intended behaviour, using the inputs now applied
    task automatic model_edge();
        longint unsigned idx;
        if (!Reset) begin
            model_reset();
        end else if (LoadInstructions) begin
            if (m_phase != P_LOAD) begin
                m_mem[0]      = Instruction;
                m_count       = 1;
                m_count_known = 1'b1;
                m_ovf         = 1'b0;
            end else if (m_count < DEPTH) begin
                m_mem[m_count] = Instruction;
                m_count        = m_count + 1;
            end else begin
                m_ovf = 1'b1;
            end
            m_phase = P_LOAD;
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_instr = NOPW;
            m_done  = 1'b0;
        end else if (m_phase == P_LOAD) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (m_count_known && m_count != 0) m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if (branch_taken) begin
                m_pc    = {branch_target[31:2], 2'b00};
                m_valid = 1'b0;
                m_instr = NOPW;
            end else if (!stall) begin
                idx = longint'(m_pc) / 4;
                if (idx < longint'(m_count)) begin
                    m_instr = m_mem[int'(idx)];
                    m_ipc   = m_pc;
                    m_ipc4  = m_pc + 32'd4;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end else begin
                    m_instr = NOPW;
                    m_valid = 1'b0;
                    m_done  = 1'b1;
                    m_phase = P_DONE;
                end
            end
        end else begin
            if (branch_taken) begin
                m_pc    = {branch_target[31:2], 2'b00};
                m_done  = 1'b0;
                m_phase = P_RUN;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("if_instr", if_instr, m_instr);
        check_eq("if_pc", if_pc, m_ipc);
        check_eq("if_pc_plus4", if_pc_plus4, m_ipc4);
        check_eq("if_valid", 32'(if_valid), 32'(m_valid));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("fetch_done", 32'(fetch_done), 32'(m_done));
        if (m_count_known) check_eq("load_count", 32'(load_count), 32'(m_count));
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the rising edge
    task automatic step(input bit r, input bit l, input logic [31:0] i,
                        input bit s, input bit b, input logic [31:0] t);
        @(negedge clk);
        Reset            = r;
        LoadInstructions = l;
        Instruction      = i;
        stall            = s;
        branch_taken     = b;
        branch_target    = t;
        if (!r) begin
            #1;
            model_reset();
            compare_all();
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] ins, input logic [31:0] pc);
        check_eq({tag, "_instr"}, if_instr, ins);
        check_eq({tag, "_pc"}, if_pc, pc);
        check_eq({tag, "_pc4"}, if_pc_plus4, pc + 32'd4);
        check_eq({tag, "_valid"}, 32'(if_valid), 32'd1);
    endtask

    initial begin
        int burst;
        logic [31:0] tgt;
        Reset = 1'b0; LoadInstructions = 1'b0; Instruction = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        m_count = 0; m_count_known = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
        model_reset();

        // Reset state
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("rst_instr", if_instr, 32'h0);
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        check_eq("rst_done", 32'(fetch_done), 32'd0);

        // Scenario 1: load A, B, C and run through to the end
        step(1'b1, 1'b1, WA, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, WB, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, WC, 1'b0, 1'b0, 32'h0);
        idle_step();
        check_eq("s1_count", 32'(load_count), 32'd3);
        idle_step();
        check_eq("s1_idle_valid", 32'(if_valid), 32'd0);
        idle_step(); expect_fetch("s1_A", WA, 32'h0);
        idle_step(); expect_fetch("s1_B", WB, 32'h4);
        idle_step(); expect_fetch("s1_C", WC, 32'h8);
        idle_step();
        check_eq("s1_end_valid", 32'(if_valid), 32'd0);
        check_eq("s1_end_instr", if_instr, 32'h0);
        check_eq("s1_end_done", 32'(fetch_done), 32'd1);

        // Scenario 2: reset pulse keeps the program
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("s2_rst_instr", if_instr, 32'h0);
        check_eq("s2_rst_pc", if_pc, 32'h0);
        check_eq("s2_rst_pc4", if_pc_plus4, 32'h0);
        check_eq("s2_rst_valid", 32'(if_valid), 32'd0);
        check_eq("s2_rst_count", 32'(load_count), 32'd3);
        idle_step();
        check_eq("s2_first_valid", 32'(if_valid), 32'd0);
        idle_step(); expect_fetch("s2_A", WA, 32'h0);

        // Scenario 3: two-cycle stall while B is held
        idle_step(); expect_fetch("s3_B", WB, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); expect_fetch("s3_stall1", WB, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); expect_fetch("s3_stall2", WB, 32'h4);
        idle_step(); expect_fetch("s3_C", WC, 32'h8);

        // Scenario 4: branch beats stall, target bits [1:0] ignored
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0003);
        check_eq("s4_bubble_valid", 32'(if_valid), 32'd0);
        check_eq("s4_bubble_instr", if_instr, 32'h0);
        check_eq("s4_bubble_pc", if_pc, 32'h8);
        idle_step(); expect_fetch("s4_A", WA, 32'h0);

        // Scenario 6: redirect out of DONE
        idle_step(); idle_step(); idle_step();
        check_eq("s6_done", 32'(fetch_done), 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004);
        check_eq("s6_redir_done", 32'(fetch_done), 32'd0);
        check_eq("s6_redir_valid", 32'(if_valid), 32'd0);
        idle_step(); expect_fetch("s6_B", WB, 32'h4);
        idle_step(); idle_step();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
        check_eq("s6_far_done0", 32'(fetch_done), 32'd0);
        idle_step();
        check_eq("s6_far_done1", 32'(fetch_done), 32'd1);
        check_eq("s6_far_valid", 32'(if_valid), 32'd0);

        // Scenario 5: overflow on a 4-deep memory
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'hA5A5_0000 + 32'(k), 1'b0, 1'b0, 32'h0);
        check_eq("s5_count", 32'(load_count), 32'd4);
        check_eq("s5_ovf", 32'(overflow), 32'd1);
        idle_step(); idle_step();
        for (int k = 0; k < 4; k++) begin
            idle_step();
            expect_fetch("s5_word", 32'hA5A5_0000 + 32'(k), 32'(4 * k));
        end
        idle_step();
        check_eq("s5_absent", 32'(fetch_done), 32'd1);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        check_eq("s5_reload_ovf", 32'(overflow), 32'd0);
        check_eq("s5_reload_count", 32'(load_count), 32'd1);

        // Randomized phase
        burst = 0;
        for (int n = 0; n < 800; n++) begin
            if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                default: tgt = 32'($urandom_range(0, 23));
            endcase
            step(($urandom_range(0, 99) != 0), (burst > 0), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), tgt);
            if (burst > 0) burst--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction-load and fetch front end that feeds the CPU's decode stage through an IF/ID register. While LoadInstructions is high it streams one 32-bit word per clock into an on-chip instruction memory. When loading ends it fetches sequentially from byte address 0, honouring stall and branch-redirect requests from downstream. Memory contents and the loaded count survive Reset, so a program loaded before a reset pulse runs after it.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words.
AW, 6, log2(DEPTH); word-index width.
NOP, 32'h00000000, instruction driven on if_instr when if_valid=0.

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
LoadInstructions  input  1  load mode; one word written per edge while high
Instruction  input  32  word to load, sampled on each edge while LoadInstructions=1
stall  input  1  hold PC and IF/ID outputs
branch_taken  input  1  redirect fetch to branch_target
branch_target  input  32  byte address of redirect; bits [1:0] ignored (forced 0)
if_instr  output  32  fetched instruction (IF/ID register)
if_pc  output  32  byte address of if_instr
if_pc_plus4  output  32  if_pc+4, mod 2^32
if_valid  output  1  if_instr is a real fetched instruction
load_count  output  AW+1  number of words loaded
overflow  output  1  a load word was dropped because memory was full
fetch_done  output  1  PC has run past the last loaded word

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset low, asynchronous: state=IDLE, pc=0, if_instr=NOP, if_pc=0, if_pc_plus4=0, if_valid=0, overflow=0, fetch_done=0.
- Reset does not clear the memory array or load_count. At power-up both are undefined until the first load.
- Priority every edge: LoadInstructions > branch_taken > stall > advance.
- LoadInstructions=1 from IDLE, RUN or DONE:
  - enter LOAD.
  - write imem[0]=Instruction; load_count=1; overflow=0.
  - pc=0; if_valid=0; if_instr=NOP; fetch_done=0.
  - Any fetch in progress is aborted.
- LOAD, LoadInstructions=1:
  - if load_count<DEPTH: write imem[load_count], then load_count+1.
  - else: drop the word, overflow=1, load_count unchanged.
- LOAD, LoadInstructions=0: go to IDLE; no write.
- IDLE, LoadInstructions=0: go to RUN if load_count!=0, else stay in IDLE. No fetch on this edge.
- RUN, normal edge (no stall, no branch), word index = pc>>2 using the full 32-bit pc:
  - if index < load_count: if_instr=imem[index], if_pc=pc, if_pc_plus4=pc+4, if_valid=1, pc=pc+4.
  - else: if_instr=NOP, if_valid=0, fetch_done=1, state=DONE.
- Fetch latency:
  - first valid instruction appears 2 edges after Reset rises, or after the first edge with LoadInstructions=0 (IDLE edge, then first RUN edge).
  - throughput is one instruction per edge thereafter.
- RUN, stall=1 and branch_taken=0: pc and all if_* outputs hold.
- RUN, branch_taken=1 (with or without stall):
  - pc={branch_target[31:2],2'b00}.
  - if_valid=0, if_instr=NOP (one bubble); if_pc and if_pc_plus4 hold.
  - the next edge fetches from the target.
- DONE:
  - outputs hold NOP, if_valid=0, fetch_done=1.
  - stall is ignored.
  - branch_taken=1: pc=target, fetch_done=0, state=RUN, and the target is fetched on the next edge.
  - a target beyond load_count returns to DONE on that next edge.
- PC arithmetic wraps mod 2^32. Any index ≥ load_count, including very large addresses, is out of range and is never a memory access.
- Memory read is synchronous; the written word is readable from the edge after the write.

Test Plan:
1. Reset; load A=32'h20010010, B=32'h20020018, C=32'h200301B4 on 3 edges; drop Load.
   - Required: load_count=3; after the IDLE edge, if_instr=A/B/C with if_pc=0/4/8 and if_valid=1 on consecutive edges.
   - Next edge: if_valid=0, if_instr=0, fetch_done=1.
2. After scenario 1, pulse Reset low for 1 cycle.
   - Required: all if_* outputs are 0 during reset; load_count stays 3; A at pc 0 appears 2 edges after release.
3. Assert stall for 2 cycles while if_instr=B.
   - Required: if_instr=B, if_pc=4, if_pc_plus4=8 for 3 edges total, then C at 8.
4. Assert branch_taken with branch_target=32'h3 while C is fetched, with stall=1 in the same cycle.
   - Required: branch wins; one edge if_valid=0; next edge A with if_pc=0.
5. DEPTH=4; load 6 words.
   - Required: load_count=4, overflow=1, words 5 and 6 absent.
   - Reloading 1 word clears overflow to 0 and sets load_count=1.
6. In DONE, branch_taken with target 32'h4.
   - Required: RUN, fetch_done=0, B fetched at if_pc=4.
   - Repeat with target 32'h100: returns to DONE with if_valid=0.
